// File: rtl/i2c_target_rx.sv
// I2C target endpoint: START/STOP decode, 7-bit address match, ACK,
// 16-bit write words to local logic, 16-bit read words to the master.
// Ports:
//   clk, RESET      system clock, sync active-high reset
//   SCL             bus clock from master (async to clk)
//   SDA_OUT, SDA_OE master SDA data / drive enable
//   TX_DATA         word returned on a read
//   SDA_IN, SDA_DRV target SDA value / target-driving flag
//   RX_DATA         last completed write word
//   RX_VALID        pulse when RX_DATA updates
//   TX_REQ          pulse when TX_DATA is sampled
//   BUSY            START seen, not yet back in IDLE
//   ERR             pulse on an aborted frame
module i2c_target_rx #(
  parameter logic [6:0] DEV_ADDR  = 7'h2A,
  parameter logic       ACK_LEVEL = 1'b1
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        SCL,
  input  logic        SDA_OUT,
  input  logic        SDA_OE,
  input  logic [15:0] TX_DATA,
  output logic        SDA_IN,
  output logic        SDA_DRV,
  output logic [15:0] RX_DATA,
  output logic        RX_VALID,
  output logic        TX_REQ,
  output logic        BUSY,
  output logic        ERR
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_MACK,
    WAIT_STOP
  } state_t;

  logic sda_bus;
  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;
  logic scl_rise, scl_fall;
  logic sda_rise, sda_fall;
  logic start, stop;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic [15:0] tx_sh;
  logic        rw;
  logic        hi_done;

  assign sda_bus = SDA_OE ? SDA_OUT : 1'b1;

  always_ff @(posedge clk) begin
    if (RESET) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= SCL;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= sda_bus;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_h;
  assign scl_fall = ~scl_s2 & scl_h;
  assign sda_rise = sda_s2 & ~sda_h;
  assign sda_fall = ~sda_s2 & sda_h;
  assign start    = sda_fall & scl_s2;
  assign stop     = sda_rise & scl_s2;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 16'h0000;
      tx_sh    <= 16'h0000;
      rw       <= 1'b0;
      hi_done  <= 1'b0;
      SDA_IN   <= ~ACK_LEVEL;
      SDA_DRV  <= 1'b0;
      RX_DATA  <= 16'h0000;
      RX_VALID <= 1'b0;
      TX_REQ   <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      RX_VALID <= 1'b0;
      TX_REQ   <= 1'b0;
      ERR      <= 1'b0;
      if (start) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        shreg   <= 16'h0000;
        hi_done <= 1'b0;
        SDA_IN  <= ~ACK_LEVEL;
        SDA_DRV <= 1'b0;
        BUSY    <= 1'b1;
      end else if (stop) begin
        // A STOP while acking the final write byte ends a
        // completed frame, so it is not an abort.
        if (state != IDLE && state != WAIT_STOP &&
            !(state == WR_ACK && hi_done))
          ERR <= 1'b1;
        state   <= IDLE;
        bit_cnt <= 4'd0;
        SDA_IN  <= ~ACK_LEVEL;
        SDA_DRV <= 1'b0;
        BUSY    <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[14:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (shreg[7:1] == DEV_ADDR) begin
                state   <= ADDR_ACK;
                rw      <= shreg[0];
                SDA_IN  <= ACK_LEVEL;
                SDA_DRV <= 1'b1;
                if (shreg[0]) begin
                  tx_sh  <= TX_DATA;
                  TX_REQ <= 1'b1;
                end
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                state   <= RD_BYTE;
                SDA_IN  <= tx_sh[15];
                SDA_DRV <= 1'b1;
                tx_sh   <= {tx_sh[14:0], 1'b0};
                bit_cnt <= 4'd1;
              end else begin
                state   <= WR_BYTE;
                SDA_IN  <= ~ACK_LEVEL;
                SDA_DRV <= 1'b0;
                bit_cnt <= 4'd0;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[14:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state   <= WR_ACK;
              bit_cnt <= 4'd0;
              SDA_IN  <= ACK_LEVEL;
              SDA_DRV <= 1'b1;
              if (hi_done) begin
                RX_DATA  <= shreg;
                RX_VALID <= 1'b1;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              SDA_IN  <= ~ACK_LEVEL;
              SDA_DRV <= 1'b0;
              if (hi_done) begin
                state <= WAIT_STOP;
              end else begin
                hi_done <= 1'b1;
                state   <= WR_BYTE;
              end
            end
          end
          RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state   <= RD_MACK;
                bit_cnt <= 4'd0;
                SDA_IN  <= ~ACK_LEVEL;
                SDA_DRV <= 1'b0;
              end else begin
                SDA_IN  <= tx_sh[15];
                SDA_DRV <= 1'b1;
                tx_sh   <= {tx_sh[14:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          RD_MACK: begin
            // Master ACK is SDA low; a high bit is a NACK.
            if (scl_rise) begin
              if (hi_done || sda_s2) begin
                if (!hi_done)
                  ERR <= 1'b1;
                state <= WAIT_STOP;
              end else begin
                hi_done <= 1'b1;
                state   <= RD_BYTE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_target_rx.md
# i2c_target_rx

I2C target (slave) endpoint that consumes the SCL/SDA bus produced by the I2C generator in this directory. It decodes START/STOP, matches a 7-bit address, and acknowledges. It delivers 16-bit write words to local logic. For read transactions it serialises a 16-bit word back to the master. In the lab top level it closes the loop for the generator: its SDA_IN output drives the generator's SDA_IN.

## Interface
- DEV_ADDR, 7'h2A, 7-bit address this target answers to.
- ACK_LEVEL, 1'b1, level driven on SDA_IN during an acknowledge slot; released level is ~ACK_LEVEL.
- clk  in  1  system clock; all logic on posedge clk.
- RESET  in  1  reset: synchronous, active-high; clock clk.
- SCL  in  1  bus clock from the master, asynchronous to clk.
- SDA_OUT  in  1  master SDA data.
- SDA_OE  in  1  master SDA drive enable. Bus SDA = SDA_OE ? SDA_OUT : 1.
- TX_DATA  in  16  word returned on a read; sampled once per read transaction.
- SDA_IN  out  1  target's SDA value toward the master; ~ACK_LEVEL when released.
- SDA_DRV  out  1  1 while the target actively drives (ACK slot or read data bit).
- RX_DATA  out  16  last completed write word, MSB first on the wire.
- RX_VALID  out  1  one-cycle pulse; RX_DATA updated the same cycle.
- TX_REQ  out  1  one-cycle pulse when TX_DATA is sampled.
- BUSY  out  1  high from the START detect until IDLE is re-entered.
- ERR  out  1  one-cycle pulse on an aborted transaction.

## Operation
- Sync: SCL and bus SDA each pass through 2 flops plus a history flop. Edge flags (scl_rise, scl_fall, sda_rise, sda_fall) come from the synchronised values.
- START: sda_fall while synced SCL=1. Valid in any state, including a repeated START mid-frame. Clears the bit counter and the shift register, then enters ADDR.
- STOP: sda_rise while synced SCL=1. From any state it goes to IDLE.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_MACK, WAIT_STOP.
- ADDR: shift bus SDA on each scl_rise, 8 bits (7 address bits, then R/W).
  - On the next scl_fall, if match and R/W=0: enter ADDR_ACK and drive ACK.
  - If match and R/W=1: enter ADDR_ACK, drive ACK, latch TX_DATA, pulse TX_REQ.
  - On mismatch: go to WAIT_STOP with SDA released.
- ADDR_ACK: release at the following scl_fall. Next state is WR_BYTE (write) or RD_BYTE (read); for a read, drive TX_DATA[15] on that same scl_fall.
- WR_BYTE and WR_ACK run twice (high byte, then low byte):
  - Shift 8 bits on scl_rise.
  - On the 8th-bit scl_fall, drive ACK in WR_ACK.
  - After the second byte: RX_DATA <= shift register and RX_VALID pulses on that same scl_fall.
  - After the second WR_ACK, go to WAIT_STOP.
- RD_BYTE and RD_MACK run twice:
  - Present the next bit on each scl_fall, MSB first.
  - After 8 bits, release for the master's ACK slot (RD_MACK) and sample the master's bit on scl_rise.
  - Master ACK after the high byte: continue with the low byte. Master NACK after the high byte: ERR pulse, go to WAIT_STOP.
  - Any response after the low byte goes to WAIT_STOP.
- STOP in any state other than IDLE/WAIT_STOP (partial frame): ERR pulse, no RX_VALID, RX_DATA unchanged.
- WAIT_STOP: SDA released; ignore bits until STOP or START.

## Timing
- Reset values: SDA_IN=~ACK_LEVEL, SDA_DRV=0, RX_DATA=16'h0000, RX_VALID=0, TX_REQ=0, BUSY=0, ERR=0, state=IDLE, sync flops=1.
- Synchroniser latency: pin edge to action is 3 clk. SDA_IN and SDA_DRV change 3 clk after the SCL pin falls.
- Master requirement: SCL high and SCL low phases each ≥4 clk; SDA stable ≥4 clk around the SCL rise.
- RESET mid-transfer: next cycle all outputs are at reset values and the target re-arms for START. A frame in flight is ignored until a new START.
- Simultaneous START detect and bit-count completion: START wins.
- RX_VALID and TX_REQ never pulse in the same cycle; ERR and RX_VALID never both pulse for one frame.

## Test plan
- Write 0x2A, data 16'hBEEF, STOP:
  - ACK_LEVEL is driven in all 3 ACK slots.
  - RX_DATA=16'hBEEF, a single RX_VALID pulse, ERR=0, BUSY falls 3 clk after STOP.
- Read 0x2A with TX_DATA=16'hA55A, master ACK then NACK:
  - SDA_IN bit stream is 1010_0101_0101_1010.
  - TX_REQ pulses once at the address ACK.
  - No ERR.
- Address 0x2B: target never drives (SDA_DRV=0 throughout), no RX_VALID, returns to IDLE on STOP.
- Write with STOP after 5 data bits: ERR pulses once, RX_DATA keeps its previous value 16'hBEEF.
- Repeated START after the first write byte, then a full write of 16'h1234: RX_DATA=16'h1234 with exactly one RX_VALID.
- RESET asserted during the 3rd read bit: next cycle SDA_DRV=0 and SDA_IN=~ACK_LEVEL; a subsequent write of 16'h00FF completes normally.
